// File: rtl/qdr_rx_write_arbiter.sv
// Round-robin write arbiter sharing the single QDR-II+ write port among the
// 1G RX FIFO ports. Tracks per-port data/metadata ring pointers and the
// committed/uncommitted/metadata occupancy that drives the free-space outputs.
module qdr_rx_write_arbiter #(
    parameter int NUM_PORTS       = 24,
    parameter int LINES_PER_PORT  = 8192,
    parameter int META_FIFO_LINES = 2048,
    parameter int ADDR_BITS       = 18,
    parameter logic [ADDR_BITS-1:0] META_BASE = 18'h30000
) (
    input  logic                                               fabric_clk,
    input  logic                                               rst,
    input  logic [NUM_PORTS-1:0]                               wr_req,
    input  logic [NUM_PORTS-1:0]                               wr_is_meta,
    input  logic [144*NUM_PORTS-1:0]                           wr_data,
    input  logic [NUM_PORTS-1:0]                               wr_abort,
    output logic [NUM_PORTS-1:0]                               wr_grant,
    input  logic [NUM_PORTS-1:0]                               rd_release,
    input  logic [($clog2(LINES_PER_PORT)+1)*NUM_PORTS-1:0]    rd_release_lines,
    output logic                                               qdr_wr_en,
    output logic [ADDR_BITS-1:0]                               qdr_wr_addr,
    output logic [143:0]                                       qdr_wr_data,
    output logic [($clog2(LINES_PER_PORT)+1)*NUM_PORTS-1:0]    data_free,
    output logic [($clog2(META_FIFO_LINES)+1)*NUM_PORTS-1:0]   meta_free,
    output logic [NUM_PORTS-1:0]                               release_err
);

    localparam int LINE_BITS = 144;
    localparam int PORT_BITS = $clog2(NUM_PORTS);
    localparam int PTR_BITS  = $clog2(LINES_PER_PORT);
    localparam int MPTR_BITS = $clog2(META_FIFO_LINES);
    localparam int DCNT_BITS = PTR_BITS + 1;
    localparam int MCNT_BITS = MPTR_BITS + 1;

    logic [PTR_BITS-1:0]  wptr_q   [NUM_PORTS];
    logic [PTR_BITS-1:0]  wptr_d   [NUM_PORTS];
    logic [PTR_BITS-1:0]  cptr_q   [NUM_PORTS];
    logic [PTR_BITS-1:0]  cptr_d   [NUM_PORTS];
    logic [MPTR_BITS-1:0] mptr_q   [NUM_PORTS];
    logic [MPTR_BITS-1:0] mptr_d   [NUM_PORTS];
    logic [DCNT_BITS-1:0] used_c_q [NUM_PORTS];
    logic [DCNT_BITS-1:0] used_c_d [NUM_PORTS];
    logic [DCNT_BITS-1:0] used_u_q [NUM_PORTS];
    logic [DCNT_BITS-1:0] used_u_d [NUM_PORTS];
    logic [MCNT_BITS-1:0] used_m_q [NUM_PORTS];
    logic [MCNT_BITS-1:0] used_m_d [NUM_PORTS];
    logic [DCNT_BITS:0]   c_sum    [NUM_PORTS];
    logic [MCNT_BITS:0]   m_sum    [NUM_PORTS];
    logic [DCNT_BITS-1:0] rel_lines[NUM_PORTS];
    logic [DCNT_BITS-1:0] dfree    [NUM_PORTS];
    logic [MCNT_BITS-1:0] mfree    [NUM_PORTS];
    logic [LINE_BITS-1:0] line     [NUM_PORTS];

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] sel_data;
    logic [NUM_PORTS-1:0] sel_meta;
    logic [NUM_PORTS-1:0] release_err_d;
    logic [PORT_BITS-1:0] rr_q;
    logic [PORT_BITS-1:0] rr_d;
    logic [PORT_BITS-1:0] grant_idx;
    logic [PORT_BITS-1:0] cand;
    logic [PORT_BITS:0]   search_sum;
    logic                 grant_valid;
    logic [ADDR_BITS-1:0] addr_d;

    // Free space per port, unpacked line view, and which ports may be granted now.
    always_comb begin
        data_free = '0;
        meta_free = '0;
        eligible  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dfree[p]     = DCNT_BITS'(LINES_PER_PORT) - used_c_q[p] - used_u_q[p];
            mfree[p]     = MCNT_BITS'(META_FIFO_LINES) - used_m_q[p];
            line[p]      = wr_data[p*LINE_BITS +: LINE_BITS];
            rel_lines[p] = rd_release_lines[p*DCNT_BITS +: DCNT_BITS];
            data_free[p*DCNT_BITS +: DCNT_BITS] = dfree[p];
            meta_free[p*MCNT_BITS +: MCNT_BITS] = mfree[p];
            eligible[p]  = wr_req[p] & ~wr_abort[p] &
                           (wr_is_meta[p] ? (mfree[p] != '0) : (dfree[p] != '0));
        end
    end

    // Round-robin search from rr, wrapping at NUM_PORTS; first eligible port wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_sum  = '0;
        cand        = '0;
        wr_grant    = '0;
        rr_d        = rr_q;
        addr_d      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            search_sum = {1'b0, rr_q} + (PORT_BITS+1)'(i);
            if (search_sum >= (PORT_BITS+1)'(NUM_PORTS)) begin
                search_sum = search_sum - (PORT_BITS+1)'(NUM_PORTS);
            end
            cand = search_sum[PORT_BITS-1:0];
            if (!rst && !grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            wr_grant[grant_idx] = 1'b1;
            rr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PORT_BITS'(1);
            if (wr_is_meta[grant_idx]) begin
                addr_d = META_BASE + ADDR_BITS'(grant_idx) * ADDR_BITS'(META_FIFO_LINES)
                       + ADDR_BITS'(mptr_q[grant_idx]);
            end else begin
                addr_d = ADDR_BITS'(grant_idx) * ADDR_BITS'(LINES_PER_PORT)
                       + ADDR_BITS'(wptr_q[grant_idx]);
            end
        end
    end

    // Per-port pointer and occupancy update: abort/write/commit, then release with clamping.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_data[p]      = grant_valid && (grant_idx == PORT_BITS'(p)) && !wr_is_meta[p];
            sel_meta[p]      = grant_valid && (grant_idx == PORT_BITS'(p)) &&  wr_is_meta[p];
            wptr_d[p]        = wptr_q[p];
            cptr_d[p]        = cptr_q[p];
            mptr_d[p]        = mptr_q[p];
            used_u_d[p]      = used_u_q[p];
            release_err_d[p] = release_err[p];

            if (wr_abort[p]) begin
                wptr_d[p]   = cptr_q[p];
                used_u_d[p] = '0;
            end else if (sel_data[p]) begin
                wptr_d[p]   = wptr_q[p] + PTR_BITS'(1);
                used_u_d[p] = used_u_q[p] + DCNT_BITS'(1);
            end else if (sel_meta[p]) begin
                cptr_d[p]   = wptr_q[p];
                used_u_d[p] = '0;
                mptr_d[p]   = mptr_q[p] + MPTR_BITS'(1);
            end

            c_sum[p] = {1'b0, used_c_q[p]} + (sel_meta[p] ? {1'b0, used_u_q[p]} : '0);
            m_sum[p] = {1'b0, used_m_q[p]} + (MCNT_BITS+1)'(sel_meta[p]);
            used_c_d[p] = c_sum[p][DCNT_BITS-1:0];
            used_m_d[p] = m_sum[p][MCNT_BITS-1:0];

            if (rd_release[p]) begin
                if ({1'b0, rel_lines[p]} > c_sum[p]) begin
                    used_c_d[p]      = '0;
                    release_err_d[p] = 1'b1;
                end else begin
                    used_c_d[p] = DCNT_BITS'(c_sum[p] - {1'b0, rel_lines[p]});
                end
                if (m_sum[p] == '0) begin
                    used_m_d[p]      = '0;
                    release_err_d[p] = 1'b1;
                end else begin
                    used_m_d[p] = MCNT_BITS'(m_sum[p] - (MCNT_BITS+1)'(1));
                end
            end
        end
    end

    // State registers and the registered QDR write port; reset drops any in-flight write.
    always_ff @(posedge fabric_clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wptr_q[p]   <= '0;
                cptr_q[p]   <= '0;
                mptr_q[p]   <= '0;
                used_c_q[p] <= '0;
                used_u_q[p] <= '0;
                used_m_q[p] <= '0;
            end
            rr_q        <= '0;
            release_err <= '0;
            qdr_wr_en   <= 1'b0;
            qdr_wr_addr <= '0;
            qdr_wr_data <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wptr_q[p]   <= wptr_d[p];
                cptr_q[p]   <= cptr_d[p];
                mptr_q[p]   <= mptr_d[p];
                used_c_q[p] <= used_c_d[p];
                used_u_q[p] <= used_u_d[p];
                used_m_q[p] <= used_m_d[p];
            end
            rr_q        <= rr_d;
            release_err <= release_err_d;
            qdr_wr_en   <= grant_valid;
            if (grant_valid) begin
                qdr_wr_addr <= addr_d;
                qdr_wr_data <= line[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_qdr_rx_write_arbiter.sv
// Self-checking bench for qdr_rx_write_arbiter: directed scenarios plus a
// randomized run, all checked against a counter-based reference model.
module tb_qdr_rx_write_arbiter;

    localparam int N = 24;
    localparam logic [N-1:0] ONE = 1;

    logic              fabric_clk = 1'b0;
    logic              rst;
    logic [N-1:0]      wr_req, wr_is_meta, wr_abort, rd_release;
    logic [N-1:0]      wr_grant, release_err;
    logic [144*N-1:0]  wr_data;
    logic [14*N-1:0]   rd_release_lines;
    logic              qdr_wr_en;
    logic [17:0]       qdr_wr_addr;
    logic [143:0]      qdr_wr_data;
    logic [14*N-1:0]   data_free;
    logic [12*N-1:0]   meta_free;

    int checks = 0;
    int errors = 0;

    // Reference model: ring positions and line counts per port.
    int m_wptr [N];
    int m_cptr [N];
    int m_mptr [N];
    int m_used_c [N];
    int m_used_u [N];
    int m_used_m [N];
    bit m_err [N];
    int m_rr;

    logic [N-1:0]  exp_grant, obs_grant;
    logic          exp_en;
    logic [17:0]   exp_addr;
    logic [143:0]  exp_data;

    qdr_rx_write_arbiter dut (
        .fabric_clk       (fabric_clk),
        .rst              (rst),
        .wr_req           (wr_req),
        .wr_is_meta       (wr_is_meta),
        .wr_data          (wr_data),
        .wr_abort         (wr_abort),
        .wr_grant         (wr_grant),
        .rd_release       (rd_release),
        .rd_release_lines (rd_release_lines),
        .qdr_wr_en        (qdr_wr_en),
        .qdr_wr_addr      (qdr_wr_addr),
        .qdr_wr_data      (qdr_wr_data),
        .data_free        (data_free),
        .meta_free        (meta_free),
        .release_err      (release_err)
    );

    always #5 fabric_clk = ~fabric_clk;

    task automatic model_reset;
        for (int p = 0; p < N; p++) begin
            m_wptr[p] = 0; m_cptr[p] = 0; m_mptr[p] = 0;
            m_used_c[p] = 0; m_used_u[p] = 0; m_used_m[p] = 0; m_err[p] = 0;
        end
        m_rr = 0; exp_en = 0; exp_addr = '0; exp_data = '0;
    endtask

    function automatic bit model_eligible(int p);
        if (!wr_req[p] || wr_abort[p]) return 0;
        if (wr_is_meta[p]) return m_used_m[p] < 2048;
        return (m_used_c[p] + m_used_u[p]) < 8192;
    endfunction

    task automatic clear_inputs;
        wr_req = '0; wr_is_meta = '0; wr_abort = '0; rd_release = '0;
        rd_release_lines = '0; wr_data = '0;
    endtask

    // Leaves time at 1ns after a rising edge with reset released.
    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge fabric_clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One clock: predict the grant from model state, then apply the cycle's effects.
    task automatic step;
        int k;
        int lines;
        @(negedge fabric_clk);
        k = -1;
        for (int i = 0; i < N; i++) begin
            if (k < 0 && model_eligible((m_rr + i) % N)) k = (m_rr + i) % N;
        end
        exp_grant = '0;
        if (k >= 0) exp_grant[k] = 1'b1;
        obs_grant = wr_grant;
        @(posedge fabric_clk);
        #1;
        if (k >= 0) begin
            exp_en = 1'b1;
            exp_data = wr_data[k*144 +: 144];
            if (wr_is_meta[k]) begin
                exp_addr = 18'('h30000 + k*2048 + m_mptr[k]);
                m_mptr[k] = (m_mptr[k] + 1) % 2048;
                m_used_c[k] += m_used_u[k];
                m_used_u[k] = 0;
                m_cptr[k] = m_wptr[k];
                m_used_m[k]++;
            end else begin
                exp_addr = 18'(k*8192 + m_wptr[k]);
                m_wptr[k] = (m_wptr[k] + 1) % 8192;
                m_used_u[k]++;
            end
            m_rr = (k + 1) % N;
        end else begin
            exp_en = 1'b0;
        end
        for (int p = 0; p < N; p++) begin
            if (wr_abort[p]) begin
                m_wptr[p] = m_cptr[p];
                m_used_u[p] = 0;
            end
            if (rd_release[p]) begin
                lines = int'(rd_release_lines[p*14 +: 14]);
                if (lines > m_used_c[p]) begin m_used_c[p] = 0; m_err[p] = 1; end
                else m_used_c[p] -= lines;
                if (m_used_m[p] == 0) m_err[p] = 1;
                else m_used_m[p]--;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        wr_req[0] = 1'b1;
        rst = 1'b1;
        #2;
        checks++;
        if (wr_grant !== '0 || qdr_wr_en !== 1'b0 || qdr_wr_addr !== '0 || qdr_wr_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: grant=%h en=%b addr=%h, required 0/0/0", wr_grant, qdr_wr_en, qdr_wr_addr);
        end
        for (int p = 0; p < N; p++) begin
            checks++;
            if (data_free[p*14 +: 14] !== 14'd8192 || meta_free[p*12 +: 12] !== 12'd2048 || release_err[p] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_free port %0d: data=%0d meta=%0d err=%b, required 8192/2048/0",
                         p, data_free[p*14 +: 14], meta_free[p*12 +: 12], release_err[p]);
            end
        end
        do_reset();
    endtask

    task automatic test_round_robin;
        logic [17:0] req_addr [4];
        req_addr[0] = 18'h00000; req_addr[1] = 18'h0A000; req_addr[2] = 18'h2E000; req_addr[3] = 18'h00001;
        do_reset();
        wr_req[0] = 1'b1; wr_req[5] = 1'b1; wr_req[23] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            wr_data[0 +: 144] = {112'd0, 32'($urandom)};
            wr_data[5*144 +: 144] = {112'd5, 32'($urandom)};
            wr_data[23*144 +: 144] = {112'd23, 32'($urandom)};
            step();
            checks++;
            if (obs_grant !== exp_grant) begin
                errors++;
                $display("[TB] FAIL rr_grant cycle %0d: got %h, required %h", c, obs_grant, exp_grant);
            end
            checks++;
            if (qdr_wr_en !== exp_en || qdr_wr_addr !== exp_addr || qdr_wr_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL rr_qdr cycle %0d: en=%b addr=%h, required en=%b addr=%h", c, qdr_wr_en, qdr_wr_addr, exp_en, exp_addr);
            end
            if (c < 4) begin
                checks++;
                if (qdr_wr_addr !== req_addr[c]) begin
                    errors++;
                    $display("[TB] FAIL rr_addr cycle %0d: got %h, required %h", c, qdr_wr_addr, req_addr[c]);
                end
            end
        end
    endtask

    task automatic test_commit;
        do_reset();
        wr_req[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_is_meta[1] = (c == 3);
            wr_data[144 +: 144] = {112'd0, 32'($urandom)};
            step();
            checks++;
            if (obs_grant !== exp_grant || qdr_wr_addr !== exp_addr || qdr_wr_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL commit_write %0d: grant=%h addr=%h, required grant=%h addr=%h", c, obs_grant, qdr_wr_addr, exp_grant, exp_addr);
            end
        end
        wr_req = '0; wr_is_meta = '0;
        checks++;
        if (qdr_wr_addr !== 18'h30800) begin
            errors++;
            $display("[TB] FAIL commit_meta_addr: got %h, required 30800", qdr_wr_addr);
        end
        checks++;
        if (data_free[14 +: 14] !== 14'd8189 || meta_free[12 +: 12] !== 12'd2047) begin
            errors++;
            $display("[TB] FAIL commit_free: data=%0d meta=%0d, required 8189/2047", data_free[14 +: 14], meta_free[12 +: 12]);
        end
    endtask

    task automatic test_abort;
        do_reset();
        wr_req[2] = 1'b1;
        repeat (4) step();
        wr_req[2] = 1'b0; wr_abort[2] = 1'b1;
        step();
        wr_abort[2] = 1'b0;
        checks++;
        if (data_free[2*14 +: 14] !== 14'd8192 || qdr_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_free: data=%0d en=%b, required 8192/0", data_free[2*14 +: 14], qdr_wr_en);
        end
        wr_req[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (qdr_wr_addr !== 18'(18'h04000 + c) || qdr_wr_en !== 1'b1) begin
                errors++;
                $display("[TB] FAIL abort_rewrite %0d: addr=%h en=%b, required %h/1", c, qdr_wr_addr, qdr_wr_en, 18'h04000 + c);
            end
        end
        wr_req[2] = 1'b0;
        checks++;
        if (data_free[2*14 +: 14] !== 14'd8190) begin
            errors++;
            $display("[TB] FAIL abort_final_free: got %0d, required 8190", data_free[2*14 +: 14]);
        end
    endtask

    task automatic test_full;
        int bad = 0;
        do_reset();
        wr_req[3] = 1'b1;
        for (int c = 0; c < 8192; c++) begin
            step();
            if (obs_grant !== (ONE << 3)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL full_fill: %0d cycles without a port 3 grant, required 0", bad);
        end
        checks++;
        if (data_free[3*14 +: 14] !== 14'd0) begin
            errors++;
            $display("[TB] FAIL full_free: got %0d, required 0", data_free[3*14 +: 14]);
        end
        wr_is_meta[3] = 1'b1;
        step();
        wr_is_meta[3] = 1'b0;
        wr_req[4] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin rd_release[3] = 1'b1; rd_release_lines[3*14 +: 14] = 14'd10; end
            step();
            rd_release = '0;
            checks++;
            if (obs_grant !== (ONE << 4) || obs_grant !== exp_grant) begin
                errors++;
                $display("[TB] FAIL full_skip %0d: grant=%h, required %h", c, obs_grant, ONE << 4);
            end
        end
        checks++;
        if (data_free[3*14 +: 14] !== 14'd10) begin
            errors++;
            $display("[TB] FAIL full_release: got %0d, required 10", data_free[3*14 +: 14]);
        end
        step();
        checks++;
        if (obs_grant !== (ONE << 3) || qdr_wr_addr !== 18'h06000) begin
            errors++;
            $display("[TB] FAIL full_resume: grant=%h addr=%h, required %h/06000", obs_grant, qdr_wr_addr, ONE << 3);
        end
    endtask

    task automatic test_abort_priority;
        do_reset();
        wr_req[6] = 1'b1; wr_abort[6] = 1'b1; wr_req[7] = 1'b1;
        step();
        checks++;
        if (obs_grant !== (ONE << 7) || qdr_wr_addr !== 18'h0E000) begin
            errors++;
            $display("[TB] FAIL abort_priority: grant=%h addr=%h, required %h/0E000", obs_grant, qdr_wr_addr, ONE << 7);
        end
    endtask

    task automatic test_release_underflow;
        do_reset();
        wr_req[8] = 1'b1;
        step(); step();
        wr_is_meta[8] = 1'b1;
        step();
        wr_req[8] = 1'b0; wr_is_meta[8] = 1'b0;
        rd_release[8] = 1'b1; rd_release_lines[8*14 +: 14] = 14'd5;
        step();
        rd_release = '0;
        checks++;
        if (data_free[8*14 +: 14] !== 14'd8192 || meta_free[8*12 +: 12] !== 12'd2048) begin
            errors++;
            $display("[TB] FAIL underflow_free: data=%0d meta=%0d, required 8192/2048", data_free[8*14 +: 14], meta_free[8*12 +: 12]);
        end
        checks++;
        if (release_err !== (ONE << 8)) begin
            errors++;
            $display("[TB] FAIL underflow_err: got %h, required %h", release_err, ONE << 8);
        end
        step();
        checks++;
        if (release_err !== (ONE << 8)) begin
            errors++;
            $display("[TB] FAIL underflow_sticky: got %h, required %h", release_err, ONE << 8);
        end
    endtask

    task automatic test_random;
        logic [14*N-1:0] e_dfree;
        logic [12*N-1:0] e_mfree;
        logic [N-1:0]    e_err;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                wr_req[p]     = ($urandom_range(0, 1) == 1);
                wr_is_meta[p] = ($urandom_range(0, 7) == 0);
                wr_abort[p]   = ($urandom_range(0, 31) == 0);
                rd_release[p] = ($urandom_range(0, 15) == 0);
                rd_release_lines[p*14 +: 14] = 14'($urandom_range(0, 6));
                wr_data[p*144 +: 144] = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            end
            step();
            checks++;
            if (obs_grant !== exp_grant) begin
                errors++;
                $display("[TB] FAIL random_grant cycle %0d: got %h, required %h", c, obs_grant, exp_grant);
            end
            checks++;
            if (qdr_wr_en !== exp_en || qdr_wr_addr !== exp_addr || qdr_wr_data !== exp_data) begin
                errors++;
                $display("[TB] FAIL random_qdr cycle %0d: en=%b addr=%h, required en=%b addr=%h", c, qdr_wr_en, qdr_wr_addr, exp_en, exp_addr);
            end
        end
        clear_inputs();
        for (int p = 0; p < N; p++) begin
            e_dfree[p*14 +: 14] = 14'(8192 - m_used_c[p] - m_used_u[p]);
            e_mfree[p*12 +: 12] = 12'(2048 - m_used_m[p]);
            e_err[p] = m_err[p];
        end
        checks++;
        if (data_free !== e_dfree) begin
            errors++;
            $display("[TB] FAIL random_data_free: got %h, required %h", data_free, e_dfree);
        end
        checks++;
        if (meta_free !== e_mfree || release_err !== e_err) begin
            errors++;
            $display("[TB] FAIL random_meta_err: err=%h, required %h", release_err, e_err);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        wr_req[0] = 1'b1; wr_req[9] = 1'b1;
        step(); step();
        checks++;
        if (qdr_wr_en !== 1'b1 || qdr_wr_addr !== 18'h12000) begin
            errors++;
            $display("[TB] FAIL midreset_pre: en=%b addr=%h, required 1/12000", qdr_wr_en, qdr_wr_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (qdr_wr_en !== 1'b0 || wr_grant !== '0 || data_free[0 +: 14] !== 14'd8192 || data_free[9*14 +: 14] !== 14'd8192) begin
            errors++;
            $display("[TB] FAIL midreset_clear: en=%b grant=%h free0=%0d, required 0/0/8192", qdr_wr_en, wr_grant, data_free[0 +: 14]);
        end
        @(posedge fabric_clk);
        #1 rst = 1'b0;
        model_reset();
        step();
        checks++;
        if (obs_grant !== (ONE << 0) || qdr_wr_addr !== 18'h00000) begin
            errors++;
            $display("[TB] FAIL midreset_restart: grant=%h addr=%h, required 1/00000", obs_grant, qdr_wr_addr);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_commit();
        test_abort();
        test_full();
        test_abort_priority();
        test_release_underflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
